// File: rtl/maxnet_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : maxnet_seq_ctrl
//  Purpose  : Sequencing controller for the Maxnet competitive-iteration
//             datapath. A run loads the four external operands, then keeps
//             reloading the feedback values until the datapath reports a
//             single survivor or the iteration limit is reached.
//
//  Ports    :
//    clk         in   1      system clock, rising edge
//    rst         in   1      asynchronous, active-low reset
//    start       in   1      level run request (sampled in IDLE and DONE)
//    dp_done     in   1      datapath: exactly one positive output remains
//    ld          out  1      datapath register load enable
//    sel         out  1      datapath mux select (0 = x1..x4, 1 = feedback)
//    busy        out  1      run in progress (INIT, EVAL, ITER)
//    done        out  1      run finished, held until start is released
//    iter_count  out  CNT_W  feedback loads in the current or last run
//    timeout     out  1      last run ended by the iteration limit
//
//  Revision : 1.0  initial release
// ============================================================================
module maxnet_seq_ctrl #(
    parameter int MAX_ITER = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dp_done,
    output logic             ld,
    output logic             sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_count,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_max_iter = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_EVAL = 3'd2,
        ST_ITER = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_iter_count;
    logic             r_timeout;
    logic             w_at_limit;
    logic             w_limit_hit;

    assign w_at_limit  = (r_iter_count == c_max_iter);
    // The limit only counts as a timeout when the datapath has not also
    // finished on the same evaluation; dp_done takes priority.
    assign w_limit_hit = (r_state == ST_EVAL) && !dp_done && w_at_limit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ld          = 1'b0;
        sel         = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                ld          = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                sel  = 1'b1;
                busy = 1'b1;
                if (dp_done || w_at_limit) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                ld          = 1'b1;
                sel         = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ST_EVAL;
            end
            ST_DONE: begin
                // Mux keeps pointing at feedback so the survivor stays
                // selected; sel returns to 0 only in IDLE/INIT.
                sel  = 1'b1;
                done = 1'b1;
                // Four-phase handshake: a held start never retriggers.
                if (!start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration counter and timeout flag. Both keep their value through
    // DONE and IDLE so the result can be read after the handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iter_count <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_iter_count <= '0;
                r_timeout    <= 1'b0;
            end else if (r_state == ST_ITER) begin
                // EVAL leaves for DONE at the limit, so this cannot wrap.
                r_iter_count <= r_iter_count + 1'b1;
            end else if (w_limit_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign iter_count = r_iter_count;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maxnet_seq_ctrl
//  Purpose  : Directed self-checking bench for maxnet_seq_ctrl
//             (MAX_ITER = 15, CNT_W = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_maxnet_seq_ctrl;

    localparam int c_max_iter = 15;
    localparam int c_cnt_w    = 4;
    localparam int c_never    = -1;

    logic               clk;
    logic               rst;
    logic               start;
    logic               dp_done;
    logic               ld;
    logic               sel;
    logic               busy;
    logic               done;
    logic [c_cnt_w-1:0] iter_count;
    logic               timeout;

    int n_checks;
    int n_fail;

    maxnet_seq_ctrl #(
        .MAX_ITER (c_max_iter),
        .CNT_W    (c_cnt_w)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dp_done    (dp_done),
        .ld         (ld),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .iter_count (iter_count),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One run. k = EVAL visit on which dp_done first rises (0 = dp_done held
    // high from the start request, c_never = never). Cycle 1 is INIT; the
    // k-th EVAL falls in cycle 2k, and done is expected in exp_done.
    task automatic run_seq(input int k, input int exp_done, input int exp_iter,
                           input bit exp_to, input int hold, input bit drop_early);
        int fb_loads;
        fb_loads = 0;
        @(negedge clk);
        start   = 1'b1;
        dp_done = (k == 0);
        for (int cyc = 1; cyc <= exp_done; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (ld && sel) fb_loads++;
            if (cyc < exp_done) begin
                check("busy_run",  busy, 1);
                check("done_run",  done, 0);
                check("ld_run",    ld,   32'(cyc % 2));
                check("sel_run",   sel,  32'(cyc != 1));
            end else begin
                check("done_rise", done, 1);
                check("busy_done", busy, 0);
                check("ld_done",   ld,   0);
            end
            dp_done = (k == 0) || (k > 0 && cyc >= 2 * k);
            if (drop_early && cyc == 2) start = 1'b0;
        end
        check("iter_count", iter_count, exp_iter);
        check("timeout",    timeout,    exp_to);
        check("fb_loads",   fb_loads,   exp_iter);
        dp_done = 1'b0;
        if (!drop_early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                check("done_held", done, 1);
                check("no_reinit", busy, 0);
            end
            start = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_ld",   ld,   0);
        check("idle_sel",  sel,  0);
        check("keep_iter", iter_count, exp_iter);
        check("keep_to",   timeout,    exp_to);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        dp_done  = 1'b0;
        #12;
        check("rst_ld",   ld,         0);
        check("rst_sel",  sel,        0);
        check("rst_busy", busy,       0);
        check("rst_done", done,       0);
        check("rst_iter", iter_count, 0);
        check("rst_to",   timeout,    0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the ITER cycle that carries iter_count=3
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_iter", iter_count, 3);
        check("pre_rst_ld",   ld,         1);
        check("pre_rst_sel",  sel,        1);
        #1 rst = 1'b0;
        #1;
        check("arst_ld",   ld,         0);
        check("arst_sel",  sel,        0);
        check("arst_busy", busy,       0);
        check("arst_done", done,       0);
        check("arst_iter", iter_count, 0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_rst_idle", busy, 0);
        end

        // Immediate finish with start held 10 cycles after done
        run_seq(0, 3, 0, 1'b0, 10, 1'b0);
        // Three iterations: dp_done from the 4th EVAL
        run_seq(4, 9, 3, 1'b0, 0, 1'b0);
        // Timeout
        run_seq(c_never, 3 + 2 * c_max_iter, c_max_iter, 1'b1, 2, 1'b0);
        // Following run finishing by dp_done clears timeout
        run_seq(2, 5, 1, 1'b0, 0, 1'b0);
        // dp_done first seen together with the iteration limit
        run_seq(c_max_iter + 1, 3 + 2 * c_max_iter, c_max_iter, 1'b0, 0, 1'b0);
        // start dropped in cycle 2: done lasts exactly one cycle
        run_seq(4, 9, 3, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
